mem_wb_pipeline_skid: RTL and testbench
=======================================

# mem_wb_pipeline_skid

Parametrised MEM/WB pipeline register for the MIPS32 core, with a valid/ready handshake on both sides and a 2-entry skid buffer. It carries the writeback control and payload fields from the MEM stage to the WB stage. Unlike a plain clocked register, it supports back-pressure from WB, synchronous flush and bubble gating of RegWrite. It sits between the data-memory stage and the register-file writeback mux.

## Interface
- DATA_WIDTH, 32, width of Read_Data and ALU_Result paths
- REG_ADDR_WIDTH, 5, width of Write_Register and Instruction_Rd fields
- Clk  in  1  rising-edge clock; the only clock
- Reset  in  1  asynchronous, active-high reset
- Flush  in  1  synchronous flush of all held entries
- Valid_MEM  in  1  MEM-side entry valid
- Ready_MEM  out  1  stage can accept an entry this cycle (registered)
- RegWrite_MEM, MemtoReg_MEM  in  1 each  control fields
- Read_Data_MEM, ALU_Result_MEM  in  DATA_WIDTH each  payload
- Write_Register_MEM, Instruction_Rd_MEM  in  REG_ADDR_WIDTH each  register addresses
- Valid_WB  out  1  WB-side entry valid
- Ready_WB  in  1  WB consumes the entry this cycle
- RegWrite_WB  out  1  RegWrite_MEM of head entry, gated by Valid_WB
- MemtoReg_WB  out  1  head entry field
- Read_Data_WB, ALU_Result_WB  out  DATA_WIDTH each  head entry fields
- Write_Register_WB, Instruction_Rd_WB  out  REG_ADDR_WIDTH each  head entry fields
- Write_Data_WB  out  DATA_WIDTH  selected writeback data; present only with MEM_WB_WRITEBACK_MUX_EN

## Operation
- Handshake signals:
  - in_fire = Valid_MEM & Ready_MEM
  - out_fire = Valid_WB & Ready_WB
- Storage: an output register (head) and a skid register. Entries leave in strict FIFO order.
- State machine (registered valids):
  - EMPTY: head invalid, skid invalid.
  - FULL: head valid, skid invalid.
  - SKID: head valid, skid valid.
- Transitions from EMPTY:
  - in_fire loads head -> FULL.
- Transitions from FULL:
  - in_fire & out_fire: load head -> FULL.
  - in_fire & !out_fire: load skid -> SKID.
  - !in_fire & out_fire -> EMPTY.
  - neither -> hold.
- Transitions from SKID:
  - out_fire: head <= skid -> FULL.
  - otherwise hold.
- Ready_MEM = 1 in EMPTY and FULL, 0 in SKID. It is driven from a register, with no combinational path from Ready_WB.
- Flush has the highest priority. Next state is EMPTY; both valids are cleared.
  - An entry accepted (in_fire) in the flush cycle is discarded.
  - Payload registers are not cleared.
- RegWrite_WB = stored RegWrite & Valid_WB. A bubble or flushed slot never writes the register file.
- While Valid_WB & !Ready_WB, all WB outputs stay stable.
- Payload registers do not change when no load occurs.

## Timing
- Reset (asynchronous, effective immediately):
  - State goes to EMPTY.
  - Ready_MEM = 1, Valid_WB = 0.
  - All payload and control outputs = 0, including Write_Data_WB.
- Latency: an entry accepted on edge N appears on the WB outputs after edge N (1 cycle) when the stage was EMPTY, or when FULL with out_fire.
- Throughput: 1 entry per cycle while Ready_WB is held high.
- Back-pressure:
  - When Ready_WB drops, at most one more entry is absorbed (into skid).
  - Ready_MEM is low from the next cycle.
- Reset deasserted mid-stream: the first accept is possible on the first rising edge after deassertion.
- Flush and Ready_WB high in the same cycle: the head is consumed (out_fire) and the stage still goes EMPTY.

## Configuration
- MEM_WB_WRITEBACK_MUX_EN defined:
  - Write_Data_WB port exists.
  - Each load computes MemtoReg ? Read_Data : ALU_Result and stores the result in head/skid.
  - It is valid in the same cycle as the other WB outputs and adds no combinational mux on the WB side.
- Not defined: the port and its registers are absent; WB performs the mux externally.

## Test plan
- Reset with Valid_MEM=1, then release; drive ALU_Result_MEM=0x0000_1234, RegWrite=1, Ready_WB=1 -> one cycle later Valid_WB=1, ALU_Result_WB=0x0000_1234, RegWrite_WB=1.
- Stream 8 entries with payloads 1..8 and Ready_WB=1 -> outputs 1..8 on 8 consecutive cycles, Ready_MEM constantly 1.
- Stream with Ready_WB=0 at entry 3 -> entries 3 and 4 held (SKID), Ready_MEM=0 next cycle. Raise Ready_WB -> outputs 3, 4, 5… in order, none lost or duplicated.
- In SKID state assert Flush for 1 cycle -> Valid_WB=0 and RegWrite_WB=0 next cycle, Ready_MEM=1. Neither flushed entry ever appears.
- Valid_MEM=0 for 2 cycles with stored RegWrite=1 -> RegWrite_WB=0 during the bubble.
- With MEM_WB_WRITEBACK_MUX_EN: entry with MemtoReg=1, Read_Data=0xDEAD_BEEF, ALU_Result=0x10 -> Write_Data_WB=0xDEAD_BEEF. With MemtoReg=0 -> 0x0000_0010.

Source files
------------

// File: rtl/mem_wb_pipeline_skid.sv
// MEM/WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional registered writeback mux enabled by defining MEM_WB_WRITEBACK_MUX_EN.
module mem_wb_pipeline_skid #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Flush,
  input  logic                      Valid_MEM,
  output logic                      Ready_MEM,
  input  logic                      RegWrite_MEM,
  input  logic                      MemtoReg_MEM,
  input  logic [DATA_WIDTH-1:0]     Read_Data_MEM,
  input  logic [DATA_WIDTH-1:0]     ALU_Result_MEM,
  input  logic [REG_ADDR_WIDTH-1:0] Write_Register_MEM,
  input  logic [REG_ADDR_WIDTH-1:0] Instruction_Rd_MEM,
  output logic                      Valid_WB,
  input  logic                      Ready_WB,
  output logic                      RegWrite_WB,
  output logic                      MemtoReg_WB,
  output logic [DATA_WIDTH-1:0]     Read_Data_WB,
  output logic [DATA_WIDTH-1:0]     ALU_Result_WB,
  output logic [REG_ADDR_WIDTH-1:0] Write_Register_WB,
`ifdef MEM_WB_WRITEBACK_MUX_EN
  output logic [REG_ADDR_WIDTH-1:0] Instruction_Rd_WB,
  output logic [DATA_WIDTH-1:0]     Write_Data_WB
`else
  output logic [REG_ADDR_WIDTH-1:0] Instruction_Rd_WB
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic                      regwrite;
    logic                      memtoreg;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
    logic [REG_ADDR_WIDTH-1:0] instr_rd;
`ifdef MEM_WB_WRITEBACK_MUX_EN
    logic [DATA_WIDTH-1:0]     write_data;
`endif
  } entry_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_ready_mem;
  entry_t r_head;
  entry_t r_skid;
  entry_t w_in;

  logic w_in_fire;
  logic w_out_fire;
  logic w_valid_wb;
  logic w_load_head_in;
  logic w_load_head_skid;
  logic w_load_skid_in;

  assign w_valid_wb = (r_state != EMPTY);
  assign w_in_fire  = Valid_MEM & r_ready_mem;
  assign w_out_fire = w_valid_wb & Ready_WB;

  always_comb begin
    w_in            = '0;
    w_in.regwrite   = RegWrite_MEM;
    w_in.memtoreg   = MemtoReg_MEM;
    w_in.read_data  = Read_Data_MEM;
    w_in.alu_result = ALU_Result_MEM;
    w_in.write_reg  = Write_Register_MEM;
    w_in.instr_rd   = Instruction_Rd_MEM;
`ifdef MEM_WB_WRITEBACK_MUX_EN
    // Mux resolved before the register so WB sees a plain flop output.
    w_in.write_data = MemtoReg_MEM ? Read_Data_MEM : ALU_Result_MEM;
`endif
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_load_head_in = 1'b1;
          w_state_nxt    = FULL;
        end
      end
      FULL: begin
        if (w_in_fire && w_out_fire) begin
          w_load_head_in = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid_in = 1'b1;
          w_state_nxt    = SKID;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (w_out_fire) begin
          w_load_head_skid = 1'b1;
          w_state_nxt      = FULL;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush discards everything, including an entry accepted this cycle.
    if (Flush) begin
      w_state_nxt      = EMPTY;
      w_load_head_in   = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= EMPTY;
      r_ready_mem <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_ready_mem <= (w_state_nxt != SKID);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head <= w_in;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid_in) begin
        r_skid <= w_in;
      end
    end
  end

  assign Ready_MEM         = r_ready_mem;
  assign Valid_WB          = w_valid_wb;
  assign RegWrite_WB       = r_head.regwrite & w_valid_wb;
  assign MemtoReg_WB       = r_head.memtoreg;
  assign Read_Data_WB      = r_head.read_data;
  assign ALU_Result_WB     = r_head.alu_result;
  assign Write_Register_WB = r_head.write_reg;
  assign Instruction_Rd_WB = r_head.instr_rd;
`ifdef MEM_WB_WRITEBACK_MUX_EN
  assign Write_Data_WB     = r_head.write_data;
`endif

endmodule

// File: tb/tb_mem_wb_pipeline_skid.sv
// Directed self-checking bench for mem_wb_pipeline_skid.
// Writeback-mux checks are compiled only when MEM_WB_WRITEBACK_MUX_EN is defined.
module tb_mem_wb_pipeline_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Flush;
  logic          Valid_MEM;
  logic          Ready_MEM;
  logic          RegWrite_MEM;
  logic          MemtoReg_MEM;
  logic [DW-1:0] Read_Data_MEM;
  logic [DW-1:0] ALU_Result_MEM;
  logic [AW-1:0] Write_Register_MEM;
  logic [AW-1:0] Instruction_Rd_MEM;
  logic          Valid_WB;
  logic          Ready_WB;
  logic          RegWrite_WB;
  logic          MemtoReg_WB;
  logic [DW-1:0] Read_Data_WB;
  logic [DW-1:0] ALU_Result_WB;
  logic [AW-1:0] Write_Register_WB;
  logic [AW-1:0] Instruction_Rd_WB;
`ifdef MEM_WB_WRITEBACK_MUX_EN
  logic [DW-1:0] Write_Data_WB;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 Clk = ~Clk;

  mem_wb_pipeline_skid #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW)
  ) dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .Flush              (Flush),
    .Valid_MEM          (Valid_MEM),
    .Ready_MEM          (Ready_MEM),
    .RegWrite_MEM       (RegWrite_MEM),
    .MemtoReg_MEM       (MemtoReg_MEM),
    .Read_Data_MEM      (Read_Data_MEM),
    .ALU_Result_MEM     (ALU_Result_MEM),
    .Write_Register_MEM (Write_Register_MEM),
    .Instruction_Rd_MEM (Instruction_Rd_MEM),
    .Valid_WB           (Valid_WB),
    .Ready_WB           (Ready_WB),
    .RegWrite_WB        (RegWrite_WB),
    .MemtoReg_WB        (MemtoReg_WB),
    .Read_Data_WB       (Read_Data_WB),
    .ALU_Result_WB      (ALU_Result_WB),
    .Write_Register_WB  (Write_Register_WB),
`ifdef MEM_WB_WRITEBACK_MUX_EN
    .Instruction_Rd_WB  (Instruction_Rd_WB),
    .Write_Data_WB      (Write_Data_WB)
`else
    .Instruction_Rd_WB  (Instruction_Rd_WB)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic rw);
    Valid_MEM          = v;
    ALU_Result_MEM     = alu;
    RegWrite_MEM       = rw;
    Write_Register_MEM = alu[AW-1:0];
    Instruction_Rd_MEM = alu[AW-1:0];
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; Ready_WB = 1'b0;
    MemtoReg_MEM = 1'b0; Read_Data_MEM = '0;
    drive(1'b1, 32'h0000_1234, 1'b1);
    step(); step();
    check("rst_ready_mem", Ready_MEM, 1);
    check("rst_valid_wb", Valid_WB, 0);
    check("rst_regwrite_wb", RegWrite_WB, 0);
    check("rst_alu_wb", ALU_Result_WB, 0);
    check("rst_rd_wb", Read_Data_WB, 0);
    check("rst_wreg_wb", Write_Register_WB, 0);
`ifdef MEM_WB_WRITEBACK_MUX_EN
    check("rst_wdata_wb", Write_Data_WB, 0);
`endif

    // First accept on first edge after release
    Reset = 1'b0; Ready_WB = 1'b1;
    step();
    check("first_valid", Valid_WB, 1);
    check("first_alu", ALU_Result_WB, 32'h0000_1234);
    check("first_regwrite", RegWrite_WB, 1);
    check("first_wreg", Write_Register_WB, 32'h14);
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("first_drain", Valid_WB, 0);

    // Streaming, one entry per cycle
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DW'(k), 1'b1);
      step();
      check($sformatf("stream_valid_%0d", k), Valid_WB, 1);
      check($sformatf("stream_alu_%0d", k), ALU_Result_WB, DW'(k));
      check($sformatf("stream_ready_%0d", k), Ready_MEM, 1);
    end
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("stream_drain", Valid_WB, 0);

    // Back-pressure into skid
    drive(1'b1, 32'd1, 1'b1); step();
    drive(1'b1, 32'd2, 1'b1); step();
    drive(1'b1, 32'd3, 1'b1); step();
    check("bp_head3", ALU_Result_WB, 3);
    Ready_WB = 1'b0;
    drive(1'b1, 32'd4, 1'b1); step();
    check("bp_hold3_a", ALU_Result_WB, 3);
    check("bp_ready_low", Ready_MEM, 0);
    drive(1'b1, 32'd5, 1'b1); step();
    check("bp_hold3_b", ALU_Result_WB, 3);
    check("bp_valid_hold", Valid_WB, 1);
    check("bp_ready_low_b", Ready_MEM, 0);
    Ready_WB = 1'b1; step();
    check("bp_out4", ALU_Result_WB, 4);
    check("bp_ready_back", Ready_MEM, 1);
    step();
    check("bp_out5", ALU_Result_WB, 5);
    drive(1'b0, 32'h0, 1'b0); step();
    check("bp_drain", Valid_WB, 0);

    // Flush while in SKID
    drive(1'b1, 32'd10, 1'b1); step();
    Ready_WB = 1'b0;
    drive(1'b1, 32'd11, 1'b1); step();
    check("fl_skid_ready", Ready_MEM, 0);
    drive(1'b0, 32'h0, 1'b0);
    Flush = 1'b1; step();
    Flush = 1'b0;
    check("fl_valid", Valid_WB, 0);
    check("fl_regwrite", RegWrite_WB, 0);
    check("fl_ready", Ready_MEM, 1);
    Ready_WB = 1'b1; step();
    check("fl_stays_empty", Valid_WB, 0);
    drive(1'b1, 32'd12, 1'b1); step();
    check("fl_next_alu", ALU_Result_WB, 12);

    // Bubble gating of RegWrite
    drive(1'b0, 32'h0, 1'b0); step();
    check("bub_regwrite_1", RegWrite_WB, 0);
    check("bub_payload_kept", ALU_Result_WB, 12);
    step();
    check("bub_regwrite_2", RegWrite_WB, 0);

    // Flush together with consume from FULL; concurrent accept is discarded
    drive(1'b1, 32'd20, 1'b1); step();
    drive(1'b1, 32'd21, 1'b1);
    Flush = 1'b1; step();
    Flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    check("flc_valid", Valid_WB, 0);
    step();
    check("flc_no_21", Valid_WB, 0);

    // Asynchronous reset mid-stream
    drive(1'b1, 32'd30, 1'b1); step();
    #2 Reset = 1'b1; #1;
    check("arst_valid", Valid_WB, 0);
    check("arst_alu", ALU_Result_WB, 0);
    step();
    Reset = 1'b0;
    drive(1'b1, 32'd31, 1'b1); step();
    check("arst_accept", ALU_Result_WB, 31);

`ifdef MEM_WB_WRITEBACK_MUX_EN
    MemtoReg_MEM = 1'b1; Read_Data_MEM = 32'hDEAD_BEEF;
    drive(1'b1, 32'h10, 1'b1); step();
    check("mux_mem", Write_Data_WB, 32'hDEAD_BEEF);
    MemtoReg_MEM = 1'b0; step();
    check("mux_alu", Write_Data_WB, 32'h0000_0010);
    drive(1'b0, 32'h0, 1'b0); step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
